cache_tag_sched: RTL and testbench

Sequencer and arbiter in front of a cache bank's tag store. It shares the tag store between three sources: the reset/flush init sweep, memory fills and core lookups. It issues at most one tag operation per cycle through a one-deep registered output stage. Downstream `stall` backpressure holds the output stage.

---
 rtl/cache_tag_sched.sv | 133 +++++++++++++
 tb/tb_cache_tag_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cache_tag_sched.sv
// cache_tag_sched
//   Shares one cache bank's tag store between three sources: the init/flush
//   invalidate sweep, memory fills and core lookups. At most one tag op is
//   issued per cycle through a one-deep registered output stage that holds
//   while the downstream stage stalls.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   stall            downstream stall; output register holds when 1
//   fill_*           fill request (valid/ready handshake, line address)
//   core_*           lookup request (valid/ready handshake, address, amo bit)
//   flush_valid      level flush request, held until flush_ready
//   flush_ready      one-cycle pulse as the flush sweep issues its last index
//   tag_*            registered tag op (lookup/fill/init one-hot, amo, address)
//   busy             1 while in INIT, FLUSH_WAIT or FLUSH
module cache_tag_sched #(
  parameter int LINES_PER_BANK  = 64,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       fill_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
  output logic                       fill_ready,
  input  logic                       core_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] core_addr,
  input  logic                       core_amo,
  output logic                       core_ready,
  input  logic                       flush_valid,
  output logic                       flush_ready,
  output logic                       tag_lookup,
  output logic                       tag_fill,
  output logic                       tag_init,
  output logic                       tag_amo_reserve,
  output logic [LINE_ADDR_WIDTH-1:0] tag_line_addr,
  output logic                       busy
);

  localparam int SEL_BITS = $clog2(LINES_PER_BANK);

  typedef enum logic [1:0] {INIT, SERVE, FLUSH_WAIT, FLUSH} state_t;

  state_t                     state_reg;
  logic [SEL_BITS-1:0]        cnt_reg;
  logic [LINE_ADDR_WIDTH-1:0] init_addr;
  logic                       out_valid;
  logic                       adv;
  logic                       last_idx;

  // The op bits are one-hot when valid, so their OR is the stage valid.
  assign out_valid = tag_lookup | tag_fill | tag_init;
  assign adv       = ~out_valid | ~stall;
  assign last_idx  = (cnt_reg == SEL_BITS'(LINES_PER_BANK - 1));

  // Zero-extend the set counter onto the line address bus.
  generate
    for (genvar gi = 0; gi < LINE_ADDR_WIDTH; gi++) begin : g_init_addr
      if (gi < SEL_BITS) begin : g_cnt
        assign init_addr[gi] = cnt_reg[gi];
      end else begin : g_zero
        assign init_addr[gi] = 1'b0;
      end
    end
  endgenerate

  // Handshakes are gated with reset so nothing is accepted (and no flush
  // completion is signalled) while the block is being reset.
  assign fill_ready  = ~reset & adv & ((state_reg == SERVE) | (state_reg == FLUSH_WAIT));
  assign core_ready  = ~reset & adv & (state_reg == SERVE) & ~fill_valid & ~flush_valid;
  assign flush_ready = ~reset & adv & (state_reg == FLUSH) & last_idx;
  assign busy        = reset | (state_reg != SERVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= INIT;
      cnt_reg         <= '0;
      tag_lookup      <= 1'b0;
      tag_fill        <= 1'b0;
      tag_init        <= 1'b0;
      tag_amo_reserve <= 1'b0;
      tag_line_addr   <= '0;
    end else begin
      // A flush request leaves SERVE even while the output stage is stalled;
      // an op accepted in this same cycle still issues below.
      if (state_reg == SERVE && flush_valid) begin
        state_reg <= FLUSH_WAIT;
      end

      if (adv) begin
        tag_lookup      <= 1'b0;
        tag_fill        <= 1'b0;
        tag_init        <= 1'b0;
        tag_amo_reserve <= 1'b0;
        tag_line_addr   <= '0;

        case (state_reg)
          INIT, FLUSH: begin
            tag_init      <= 1'b1;
            tag_line_addr <= init_addr;
            cnt_reg       <= cnt_reg + 1'b1;   // wraps to 0 after the last index
            if (last_idx) begin
              state_reg <= SERVE;
            end
          end
          SERVE: begin
            if (fill_valid) begin
              tag_fill      <= 1'b1;
              tag_line_addr <= fill_addr;
            end else if (core_valid && !flush_valid) begin
              tag_lookup      <= 1'b1;
              tag_amo_reserve <= core_amo;
              tag_line_addr   <= core_addr;
            end
          end
          FLUSH_WAIT: begin
            // Drain pending fills first; the hand-over cycle issues no op.
            if (fill_valid) begin
              tag_fill      <= 1'b1;
              tag_line_addr <= fill_addr;
            end else begin
              state_reg <= FLUSH;
            end
          end
          default: begin
            state_reg <= INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_sched.sv
module tb_cache_tag_sched;

  localparam int LPB = 4;
  localparam int AW  = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic          fill_ready;
  logic          core_valid;
  logic [AW-1:0] core_addr;
  logic          core_amo;
  logic          core_ready;
  logic          flush_valid;
  logic          flush_ready;
  logic          tag_lookup;
  logic          tag_fill;
  logic          tag_init;
  logic          tag_amo_reserve;
  logic [AW-1:0] tag_line_addr;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_tag_sched #(.LINES_PER_BANK(LPB), .LINE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_ready(fill_ready),
    .core_valid(core_valid), .core_addr(core_addr), .core_amo(core_amo),
    .core_ready(core_ready),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .tag_lookup(tag_lookup), .tag_fill(tag_fill), .tag_init(tag_init),
    .tag_amo_reserve(tag_amo_reserve), .tag_line_addr(tag_line_addr),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Packs {lookup, fill, init, amo, addr} so one comparison covers the op.
  task automatic chk_op(input string name, input logic lk, input logic fl, input logic in,
                        input logic amo, input logic [AW-1:0] addr);
    chk(name, {2'b00, tag_lookup, tag_fill, tag_init, tag_amo_reserve, tag_line_addr},
              {2'b00, lk, fl, in, amo, addr});
  endtask

  task automatic chk_hs(input string name, input logic fr, input logic cr, input logic flr,
                        input logic bz);
    #1;
    chk(name, {28'd0, fill_ready, core_ready, flush_ready, busy}, {28'd0, fr, cr, flr, bz});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    fill_valid = 1'b0; fill_addr = '0;
    core_valid = 1'b0; core_addr = '0; core_amo = 1'b0;
    flush_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk_op("rst_op", 0, 0, 0, 0, 0);
    chk_hs("rst_hs", 0, 0, 0, 1);

    // Unstalled init sweep: addresses 0..3, SERVE reached as 3 issues
    reset = 1'b0;
    tick(); chk_op("init0", 0, 0, 1, 0, 0); chk_hs("init0_hs", 0, 0, 0, 1);
    tick(); chk_op("init1", 0, 0, 1, 0, 1);
    tick(); chk_op("init2", 0, 0, 1, 0, 2);
    tick(); chk_op("init3", 0, 0, 1, 0, 3); chk_hs("init3_hs", 1, 1, 0, 0);
    tick(); chk_op("idle", 0, 0, 0, 0, 0);

    // Init sweep with a stall while index 2 is presented
    reset = 1'b1; tick(); reset = 1'b0;
    chk_op("rst2_op", 0, 0, 0, 0, 0);
    tick(); chk_op("s_init0", 0, 0, 1, 0, 0);
    tick(); chk_op("s_init1", 0, 0, 1, 0, 1);
    tick(); chk_op("s_init2", 0, 0, 1, 0, 2);
    stall = 1'b1;
    tick(); chk_op("s_init2_hold", 0, 0, 1, 0, 2); chk_hs("s_hold_hs", 0, 0, 0, 1);
    stall = 1'b0;
    tick(); chk_op("s_init3", 0, 0, 1, 0, 3); chk_hs("s_init3_hs", 1, 1, 0, 0);

    // Fill wins over core; core issues on the following cycle
    fill_valid = 1'b1; fill_addr = 26'h10;
    core_valid = 1'b1; core_addr = 26'h20; core_amo = 1'b1;
    chk_hs("prio_hs", 1, 0, 0, 0);
    tick(); chk_op("fill10", 0, 1, 0, 0, 26'h10);
    fill_valid = 1'b0;
    chk_hs("core_hs", 1, 1, 0, 0);
    tick(); chk_op("look20", 1, 0, 0, 1, 26'h20);
    core_valid = 1'b0;

    // Stall with a valid op holds the stage and blocks acceptance
    stall = 1'b1;
    fill_valid = 1'b1; fill_addr = 26'h40;
    core_valid = 1'b1; core_addr = 26'h30; core_amo = 1'b0;
    chk_hs("stall_hs", 0, 0, 0, 0);
    tick(); chk_op("stall_hold1", 1, 0, 0, 1, 26'h20);
    tick(); chk_op("stall_hold2", 1, 0, 0, 1, 26'h20);
    stall = 1'b0; fill_valid = 1'b0;
    tick(); chk_op("look30", 1, 0, 0, 0, 26'h30);
    core_valid = 1'b0;
    tick(); chk_op("idle2", 0, 0, 0, 0, 0);

    // Flush with two trailing fills; core blocked throughout
    flush_valid = 1'b1; fill_valid = 1'b1; fill_addr = 26'h50;
    core_valid = 1'b1; core_addr = 26'h60; core_amo = 1'b0;
    chk_hs("fl_req_hs", 1, 0, 0, 0);
    tick(); chk_op("fl_fill50", 0, 1, 0, 0, 26'h50);
    fill_addr = 26'h51;
    chk_hs("fl_wait_hs", 1, 0, 0, 1);
    tick(); chk_op("fl_fill51", 0, 1, 0, 0, 26'h51);
    fill_valid = 1'b0;
    tick(); chk_op("fl_gap", 0, 0, 0, 0, 0); chk_hs("fl_gap_hs", 0, 0, 0, 1);
    tick(); chk_op("fl_init0", 0, 0, 1, 0, 0); chk_hs("fl_i0_hs", 0, 0, 0, 1);
    tick(); chk_op("fl_init1", 0, 0, 1, 0, 1); chk_hs("fl_i1_hs", 0, 0, 0, 1);
    tick(); chk_op("fl_init2", 0, 0, 1, 0, 2); chk_hs("fl_done_hs", 0, 0, 1, 1);
    flush_valid = 1'b0;
    tick(); chk_op("fl_init3", 0, 0, 1, 0, 3); chk_hs("fl_serve_hs", 1, 1, 0, 0);
    tick(); chk_op("look60", 1, 0, 0, 0, 26'h60);
    core_valid = 1'b0;

    // Reset during a flush sweep aborts it with no completion pulse
    flush_valid = 1'b1;
    tick(); chk_op("rf_wait", 0, 0, 0, 0, 0);
    tick(); chk_op("rf_gap", 0, 0, 0, 0, 0);
    tick(); chk_op("rf_init0", 0, 0, 1, 0, 0);
    tick(); chk_op("rf_init1", 0, 0, 1, 0, 1);
    tick(); chk_op("rf_init2", 0, 0, 1, 0, 2);
    reset = 1'b1;
    chk_hs("rf_rst_hs", 0, 0, 0, 1);
    tick(); chk_op("rf_rst_op", 0, 0, 0, 0, 0);
    reset = 1'b0;
    // flush_valid stays high: ignored during INIT
    tick(); chk_op("ri_init0", 0, 0, 1, 0, 0); chk_hs("ri_i0_hs", 0, 0, 0, 1);
    tick(); chk_op("ri_init1", 0, 0, 1, 0, 1);
    tick(); chk_op("ri_init2", 0, 0, 1, 0, 2); chk_hs("ri_i2_hs", 0, 0, 0, 1);
    tick(); chk_op("ri_init3", 0, 0, 1, 0, 3); chk_hs("ri_serve_hs", 1, 0, 0, 0);
    tick(); chk_op("ri_flwait", 0, 0, 0, 0, 0); chk_hs("ri_flwait_hs", 1, 0, 0, 1);
    flush_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
